// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port byte-addressed data memory.
// Optional grant statistics are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int   ADDR_W    = 32,
  parameter int   DATA_W    = 32,
  parameter logic INIT_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [2:0]        ctrl0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [2:0]        ctrl1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack1,
  output logic              mem_write,
  output logic [2:0]        mem_ctrl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  localparam logic [2:0] CTRL_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                last;
  logic                grant, grant_id;
  logic                win_p0, we_p0;
  logic [2:0]          ctrl_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (req0 && req1) begin
          grant    = 1'b1;
          grant_id = ~last;
        end else if (req0) begin
          grant    = 1'b1;
        end else if (req1) begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end
        if (grant) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: capture the winning request in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= INIT_LAST;
      win_p0   <= 1'b0;
      we_p0    <= 1'b0;
      ctrl_p0  <= CTRL_NOP;
      addr_p0  <= '0;
      wdata_p0 <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        win_p0   <= grant_id;
        we_p0    <= grant_id ? we1    : we0;
        ctrl_p0  <= grant_id ? ctrl1  : ctrl0;
        addr_p0  <= grant_id ? addr1  : addr0;
        wdata_p0 <= grant_id ? wdata1 : wdata0;
      end
      if (state == RESP) last <= win_p0;
    end
  end

  // Stage p1: memory access, read data registered for the winner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS) begin
      if (win_p0) rdata1 <= mem_rdata;
      else        rdata0 <= mem_rdata;
    end
  end

  assign mem_write = (state == ACCESS) && we_p0;
  assign mem_ctrl  = (state == ACCESS) ? ctrl_p0 : CTRL_NOP;
  assign mem_addr  = addr_p0;
  assign mem_wdata = wdata_p0;
  assign busy      = (state != IDLE);

  // Stage p2: response cycle
  assign ack0 = (state == RESP) && !win_p0;
  assign ack1 = (state == RESP) &&  win_p0;

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (stats_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (ack0) grant_cnt0 <= sat_inc(grant_cnt0);
      if (ack1) grant_cnt1 <= sat_inc(grant_cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte memory environment plus a
// transaction-level reference model (round-robin order, shadow memory, held read data).
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          r_req   [2];
  logic          f_we    [2];
  logic [2:0]    f_ctrl  [2];
  logic [AW-1:0] f_addr  [2];
  logic [DW-1:0] f_wdata [2];
  logic [DW-1:0] rdata0, rdata1;
  logic          ack0, ack1, mem_write, busy;
  logic [2:0]    mem_ctrl;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic          stats_clr;
  logic [15:0]   grant_cnt0, grant_cnt1;
`endif

  int tests = 0;
  int fails = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_LAST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0(r_req[0]), .we0(f_we[0]), .ctrl0(f_ctrl[0]), .addr0(f_addr[0]),
    .wdata0(f_wdata[0]), .rdata0(rdata0), .ack0(ack0),
    .req1(r_req[1]), .we1(f_we[1]), .ctrl1(f_ctrl[1]), .addr1(f_addr[1]),
    .wdata1(f_wdata[1]), .rdata1(rdata1), .ack1(ack1),
    .mem_write(mem_write), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Memory environment: 256 bytes, sync write, combinational formatted read
  logic [7:0] mem [256];
  logic       mem_load;

  function automatic logic [31:0] env_fmt(input logic [2:0] c, input logic [31:0] w);
    case (c)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    logic [7:0] a;
    a = mem_addr[7:0];
    mem_rdata = env_fmt(mem_ctrl, {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]});
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_ctrl[1:0] != 2'b00) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (mem_ctrl[1:0] == 2'b10) begin
        mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [256];
  logic        last_m;
  logic [31:0] held   [2];
  bit          held_v [2];
  int          cnt_m  [2];

  function automatic logic [31:0] ref_read(input logic [2:0] c, input logic [31:0] addr);
    int b, h;
    logic [7:0] a;
    a = addr[7:0];
    b = int'(ref_mem[a]);
    h = b + 256 * int'(ref_mem[a + 8'd1]);
    case (c)
      3'b000:  return 32'((b >= 128) ? b - 256 : b);
      3'b001:  return 32'((h >= 32768) ? h - 65536 : h);
      3'b010:  return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_write(input logic [2:0] c, input logic [31:0] addr, input logic [31:0] d);
    int n;
    n = (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[8'(addr[7:0] + i)] = d[8*i +: 8];
  endtask

  task automatic model_reset();
    last_m = 1'b1;
    for (int p = 0; p < 2; p++) begin
      held[p] = 32'd0;
      held_v[p] = 1'b1;
      cnt_m[p] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_ctrl", mem_ctrl, 3'b111);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_cnt0", grant_cnt0, 0);
    chk("rst_cnt1", grant_cnt1, 0);
`endif
  endtask

  // Model bookkeeping when port p is acked; returns nothing, checks read data
  task automatic on_ack(input int p);
    logic [31:0] e;
    if (!f_we[p]) begin
      e = ref_read(f_ctrl[p], f_addr[p]);
      if (p == 1) chk("rdata1", rdata1, e);
      else        chk("rdata0", rdata0, e);
      held[p] = e;
      held_v[p] = 1'b1;
    end else begin
      ref_write(f_ctrl[p], f_addr[p], f_wdata[p]);
      held_v[p] = 1'b0;
    end
    if (held_v[1-p]) begin
      if (p == 1) chk("rdata0_hold", rdata0, held[0]);
      else        chk("rdata1_hold", rdata1, held[1]);
    end
    last_m = (p == 1);
    cnt_m[p]++;
  endtask

  // Issue requests from one or both ports (called in IDLE, #1 after an edge)
  task automatic run_txn(input bit use0, input bit use1);
    int t [2];
    bit act [2];
    int nk, first;
    act[0] = use0;
    act[1] = use1;
    t[0] = 0;
    t[1] = 0;
    if (use0 && use1) begin
      first = last_m ? 0 : 1;
      t[first] = 2;
      t[1-first] = 5;
      nk = 6;
    end else begin
      t[use1 ? 1 : 0] = 2;
      nk = 3;
    end
    r_req[0] = use0;
    r_req[1] = use1;
    for (int k = 1; k <= nk; k++) begin
      logic e_wr, e_busy;
      logic [2:0] e_ctrl;
      tick();
      e_wr = 1'b0;
      e_busy = 1'b0;
      e_ctrl = 3'b111;
      for (int p = 0; p < 2; p++) begin
        if (act[p] && k == t[p] - 1) begin
          e_busy = 1'b1;
          e_wr = f_we[p];
          e_ctrl = f_ctrl[p];
          chk("mem_addr", mem_addr, f_addr[p]);
          if (f_we[p]) chk("mem_wdata", mem_wdata, f_wdata[p]);
        end
        if (act[p] && k == t[p]) e_busy = 1'b1;
      end
      chk("ack0", ack0, act[0] && k == t[0]);
      chk("ack1", ack1, act[1] && k == t[1]);
      chk("mem_write", mem_write, e_wr);
      chk("mem_ctrl", mem_ctrl, e_ctrl);
      chk("busy", busy, e_busy);
      for (int p = 0; p < 2; p++) begin
        if (act[p] && k == t[p]) begin
          on_ack(p);
          r_req[p] = 1'b0;
        end
      end
    end
  endtask

  task automatic set_port(input int p, input logic we, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] d);
    f_we[p] = we;
    f_ctrl[p] = c;
    f_addr[p] = a;
    f_wdata[p] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rd_ctrls [5];
    int n_ack, mode;
    rd_ctrls = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reset = 1'b0;
    mem_load = 1'b1;
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0;
      set_port(p, 1'b0, 3'b010, 32'd0, 32'd0);
    end
`ifdef DMEM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
    model_reset();
    tick();
    mem_load = 1'b0;
    check_reset_vals();
    tick();
    reset = 1'b1;

    // Single write then read-back through the other port
    set_port(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    run_txn(1, 0);
    set_port(1, 1'b0, 3'b010, 32'h10, 32'h0);
    run_txn(0, 1);
    chk("readback_const", rdata1, 32'hDEADBEEF);

    // Signed versus unsigned byte read
    set_port(1, 1'b1, 3'b000, 32'h20, 32'h00000080);
    run_txn(0, 1);
    set_port(0, 1'b0, 3'b000, 32'h20, 32'h0);
    run_txn(1, 0);
    chk("sbyte_const", rdata0, 32'hFFFFFF80);
    set_port(0, 1'b0, 3'b100, 32'h20, 32'h0);
    run_txn(1, 0);
    chk("ubyte_const", rdata0, 32'h00000080);

    // Continuous contention from reset: alternate 0,1,0,1 every 3 cycles
    reset = 1'b0;
    set_port(0, 1'b0, 3'b010, 32'h40, 32'h0);
    set_port(1, 1'b0, 3'b101, 32'h46, 32'h0);
    r_req[0] = 1'b1;
    r_req[1] = 1'b1;
    tick();
    tick();
    model_reset();
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      int p;
      tick();
      p = (k % 3 == 2) ? ((k / 3) % 2) : -1;
      chk("cont_ack0", ack0, p == 0);
      chk("cont_ack1", ack1, p == 1);
      chk("cont_excl", ack0 && ack1, 0);
      if (p >= 0) on_ack(p);
    end
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    tick();

    // One-cycle request pulse on port 1 still completes exactly once
    set_port(1, 1'b0, 3'b001, 32'h52, 32'h0);
    r_req[1] = 1'b1;
    n_ack = 0;
    tick();
    r_req[1] = 1'b0;
    chk("drop_busy", busy, 1);
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk("drop_ack0", ack0, 0);
      chk("drop_ack1", ack1, k == 2);
      if (ack1) n_ack++;
      if (k == 2) on_ack(1);
    end
    chk("drop_ack_count", n_ack, 1);

    // Reset falling during ACCESS aborts the write
    set_port(0, 1'b1, 3'b000, 32'h30, 32'h55);
    r_req[0] = 1'b1;
    tick();
    chk("abort_in_access", mem_write, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    r_req[0] = 1'b0;
    tick();
    chk("abort_ack0", ack0, 0);
    reset = 1'b1;
    set_port(1, 1'b0, 3'b100, 32'h30, 32'h0);
    run_txn(0, 1);
    chk("abort_byte_const", rdata1, 32'h000000F5);

    // Randomized single and contended transactions
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      for (int p = 0; p < 2; p++) begin
        logic we;
        logic [2:0] c;
        logic [31:0] a;
        we = 1'($urandom_range(0, 1));
        c = we ? rd_ctrls[$urandom_range(0, 2)] : rd_ctrls[$urandom_range(0, 4)];
        a = $urandom;
        if (c[1:0] == 2'b10) a[1:0] = 2'b00;
        if (c[1:0] == 2'b01) a[0] = 1'b0;
        set_port(p, we, c, a, $urandom);
      end
      run_txn(mode != 1, mode != 0);
    end

`ifdef DMEM_ARB_STATS_EN
    reset = 1'b0;
    tick();
    check_reset_vals();
    model_reset();
    reset = 1'b1;
    set_port(0, 1'b0, 3'b010, 32'h60, 32'h0);
    set_port(1, 1'b0, 3'b010, 32'h64, 32'h0);
    for (int i = 0; i < 3; i++) run_txn(1, 1);
    for (int i = 0; i < 2; i++) run_txn(1, 0);
    chk("grant_cnt0", grant_cnt0, cnt_m[0]);
    chk("grant_cnt1", grant_cnt1, cnt_m[1]);
    chk("grant_cnt0_const", grant_cnt0, 5);
    chk("grant_cnt1_const", grant_cnt1, 3);
    r_req[0] = 1'b1;
    tick();
    tick();
    chk("clr_in_resp", ack0, 1);
    stats_clr = 1'b1;
    r_req[0] = 1'b0;
    tick();
    stats_clr = 1'b0;
    chk("clr_cnt0", grant_cnt0, 0);
    chk("clr_cnt1", grant_cnt1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port byte-addressed data memory (sync write, combinational read, 3-bit size control).
- Port 0 serves the core load/store path; port 1 serves a loader/DMA agent.
- Round-robin grant, one transaction in flight, fixed 3-state sequence per access.
- Registered response data and a one-cycle ack pulse per requester.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory side.
- DATA_W, 32, data width for write data and read data.
- INIT_LAST, 1, value of the last-granted pointer at reset; 1 means port 0 wins the first tie.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held until ack0.
- we0  in  1  port 0 write enable.
- ctrl0  in  3  port 0 size control: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- addr0  in  ADDR_W  port 0 byte address.
- wdata0  in  DATA_W  port 0 write data.
- rdata0  out  DATA_W  port 0 read data; valid while ack0=1.
- ack0  out  1  port 0 completion pulse.
- req1, we1, ctrl1, addr1, wdata1, rdata1, ack1  same as the port 0 group, for port 1.
- mem_write  out  1  memory write strobe.
- mem_ctrl  out  3  memory size control.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, combinational.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset values (asserted asynchronously when reset=0):
  - state=IDLE, last=INIT_LAST.
  - ack0=ack1=0, rdata0=rdata1=0.
  - mem_write=0, mem_ctrl=3'b111 (no-op), mem_addr=0, mem_wdata=0, busy=0.
- State IDLE:
  - No request: stay in IDLE.
  - Exactly one reqN: that port wins.
  - Both requests: the port other than last wins.
  - On a win: capture winner id, we, ctrl, addr and wdata into registers, then go to ACCESS.
- State ACCESS (exactly 1 cycle):
  - Drive mem_* from the captured registers.
  - mem_write = captured we, so the write commits on the clock edge that leaves ACCESS.
  - Capture mem_rdata into the winner's rdata register. For writes, rdata is captured but meaningless.
  - Go to RESP.
- State RESP (exactly 1 cycle):
  - ackN=1 for the winner only; mem_write=0, mem_ctrl=3'b111.
  - last is updated to the winner id; next state is IDLE.
- Outside ACCESS: mem_write=0 and mem_ctrl=3'b111.
- rdataN holds its value until that port's next transaction.
- Latency: req sampled at edge E → ACCESS after E → ack high in the cycle after E+1. Minimum spacing between consecutive grants is 3 cycles.
- Requester protocol:
  - Hold req and all fields stable until ack. Fields are sampled only in IDLE, so later changes are ignored.
  - A requester that deasserts req after being granted still gets its transaction completed and acked.
  - A requester that keeps req high in the cycle after ack starts a new transaction, subject to round-robin.
- Simultaneous events:
  - If the other port requests while a transaction is in flight, it waits.
  - Under continuous contention grants alternate strictly 0,1,0,1 (starting with 0 from reset).
- Reset mid-transaction: abort, return to IDLE, no ack issued. A write in ACCESS is not committed if reset falls before the edge.
- Widths: mem_addr and mem_wdata pass through without modification. Alignment and sign extension are the memory's job.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each).
  - A counter increments on each RESP cycle of its port and saturates at 16'hFFFF.
  - Both counters clear on reset.
  - Adds input stats_clr (1 bit), a synchronous clear that takes priority over increment in the same cycle.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single write: req0=1, we0=1, ctrl0=010, addr0=0x10, wdata0=0xDEADBEEF → mem_write=1 for exactly 1 cycle at addr 0x10; ack0 pulses 2 cycles after the req sample; a later read via port 1 (ctrl1=010, addr 0x10) returns rdata1=0xDEADBEEF.
- Signed/unsigned read: memory byte 0x20=0x80; port 0 reads with ctrl=000 → rdata0=0xFFFFFF80; then ctrl=100 → rdata0=0x00000080.
- Contention: req0 and req1 held high from reset for 12 cycles → ack sequence 0,1,0,1 with acks every 3 cycles; ack0 and ack1 never high together.
- Early drop: req1 pulsed for 1 cycle while IDLE → transaction completes and ack1 pulses once; no second grant occurs.
- Reset mid-ACCESS: port 0 write of 0x55 to 0x30 pulled to reset=0 during ACCESS before the edge → no write (byte 0x30 unchanged), ack0 never pulses, all outputs return to their reset values immediately.
- Stats (DMEM_ARB_STATS_EN): 5 port-0 and 3 port-1 transactions → grant_cnt0=5, grant_cnt1=3; stats_clr asserted together with a RESP → counter reads 0.
